// File: rtl/register_file_multi_port_bist.sv
// Flip-flop register file with N_WRITE write ports, N_READ registered read ports
// and an integrated March C- self-test engine that owns the array while busy.
module register_file_multi_port_bist #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_READ     = 2,
  parameter int N_WRITE    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_READ-1:0]            ReadEnable,
  input  logic [N_READ*ADDR_WIDTH-1:0] ReadAddr,
  output logic [N_READ*DATA_WIDTH-1:0] ReadData,
  input  logic [N_WRITE-1:0]           WriteEnable,
  input  logic [N_WRITE*ADDR_WIDTH-1:0] WriteAddr,
  input  logic [N_WRITE*DATA_WIDTH-1:0] WriteData,
  input  logic                         bist_start_i,
  output logic                         bist_busy_o,
  output logic                         bist_done_o,
  output logic                         bist_fail_o,
  output logic [ADDR_WIDTH-1:0]        bist_fail_addr_o
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    IDLE, W0_UP, R0W1_UP, R1W0_UP, R0W1_DN, R1W0_DN, R0_DN, DONE
  } state_t;

  state_t state, state_nxt;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [ADDR_WIDTH-1:0]            addr;
  logic                             phase;
  logic [DATA_WIDTH-1:0]            bist_rd;

  logic is_dn, single, exp_one, wr_one, wr_en, cmp_en, step, last, next_dn;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bist_start_i) state_nxt = W0_UP;
      W0_UP:   if (last) state_nxt = R0W1_UP;
      R0W1_UP: if (last) state_nxt = R1W0_UP;
      R1W0_UP: if (last) state_nxt = R0W1_DN;
      R0W1_DN: if (last) state_nxt = R1W0_DN;
      R1W0_DN: if (last) state_nxt = R0_DN;
      R0_DN:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Two-cycle elements: phase 0 captures the word, phase 1 compares and writes.
  always_comb begin
    is_dn   = 1'b0;
    single  = 1'b0;
    exp_one = 1'b0;
    wr_one  = 1'b0;
    wr_en   = 1'b0;
    cmp_en  = 1'b0;
    case (state)
      W0_UP:   begin single = 1'b1; wr_en = 1'b1; end
      R0W1_UP: begin wr_one = 1'b1; wr_en = phase; cmp_en = phase; end
      R1W0_UP: begin exp_one = 1'b1; wr_en = phase; cmp_en = phase; end
      R0W1_DN: begin is_dn = 1'b1; wr_one = 1'b1; wr_en = phase; cmp_en = phase; end
      R1W0_DN: begin is_dn = 1'b1; exp_one = 1'b1; wr_en = phase; cmp_en = phase; end
      R0_DN:   begin is_dn = 1'b1; cmp_en = phase; end
      default: ;
    endcase
    step        = single | phase;
    last        = step && (addr == (is_dn ? '0 : ADDR_LAST));
    next_dn     = is_dn | (state == R1W0_UP);
    bist_busy_o = (state != IDLE);
    bist_done_o = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr             <= '0;
      phase            <= 1'b0;
      bist_rd          <= '0;
      bist_fail_o      <= 1'b0;
      bist_fail_addr_o <= '0;
    end else if (state == IDLE) begin
      if (bist_start_i) begin
        addr             <= '0;
        phase            <= 1'b0;
        bist_fail_o      <= 1'b0;
        bist_fail_addr_o <= '0;
      end
    end else if (state != DONE) begin
      if (!single) phase <= ~phase;
      if (!single && !phase) bist_rd <= mem[addr];
      if (cmp_en && (bist_rd != {DATA_WIDTH{exp_one}}) && !bist_fail_o) begin
        bist_fail_o      <= 1'b1;
        bist_fail_addr_o <= addr;
      end
      if (step) begin
        if (last)       addr <= next_dn ? ADDR_LAST : '0;
        else if (is_dn) addr <= addr - 1'b1;
        else            addr <= addr + 1'b1;
      end
    end
  end

  // Later ports overwrite earlier ones in loop order, so the highest index wins.
  always_ff @(posedge clk) begin
    if (bist_busy_o) begin
      if (wr_en) mem[addr] <= {DATA_WIDTH{wr_one}};
    end else begin
      for (int unsigned i = 0; i < N_WRITE; i++) begin
        if (WriteEnable[i])
          mem[WriteAddr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= WriteData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ReadData <= '0;
    end else if (!bist_busy_o) begin
      for (int unsigned i = 0; i < N_READ; i++) begin
        if (ReadEnable[i])
          ReadData[i*DATA_WIDTH +: DATA_WIDTH] <= mem[ReadAddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
  end

endmodule

// File: tb/tb_register_file_multi_port_bist.sv
// Directed bench for register_file_multi_port_bist: functional ports, March C- timing,
// stuck-at detection and reset during a running self-test.
module tb_register_file_multi_port_bist;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    ReadEnable;
  logic [2*AW-1:0] ReadAddr;
  logic [2*DW-1:0] ReadData;
  logic [1:0]    WriteEnable;
  logic [2*AW-1:0] WriteAddr;
  logic [2*DW-1:0] WriteData;
  logic          bist_start_i;
  logic          bist_busy_o;
  logic          bist_done_o;
  logic          bist_fail_o;
  logic [AW-1:0] bist_fail_addr_o;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  register_file_multi_port_bist #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .N_READ(2),
    .N_WRITE(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ReadEnable(ReadEnable),
    .ReadAddr(ReadAddr),
    .ReadData(ReadData),
    .WriteEnable(WriteEnable),
    .WriteAddr(WriteAddr),
    .WriteData(WriteData),
    .bist_start_i(bist_start_i),
    .bist_busy_o(bist_busy_o),
    .bist_done_o(bist_done_o),
    .bist_fail_o(bist_fail_o),
    .bist_fail_addr_o(bist_fail_addr_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulses start and counts cycles until done; cycle 1 is the one after the start edge.
  task automatic run_bist(output int cycles);
    bist_start_i = 1'b1;
    tick();
    bist_start_i = 1'b0;
    cycles = 1;
    while (!bist_done_o && cycles < 1000) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    ReadEnable   = '0;
    ReadAddr     = '0;
    WriteEnable  = '0;
    WriteAddr    = '0;
    WriteData    = '0;
    bist_start_i = 1'b0;
    tick();
    tick();
    check("rst_rdata", 64'(ReadData), 64'h0);
    check("rst_busy", 64'(bist_busy_o), 64'h0);
    check("rst_done", 64'(bist_done_o), 64'h0);
    check("rst_fail", 64'(bist_fail_o), 64'h0);
    check("rst_faddr", 64'(bist_fail_addr_o), 64'h0);
    rst_n = 1'b1;

    // T1: write p0, read both ports
    WriteEnable = 2'b01; WriteAddr = {5'd0, 5'd3}; WriteData = {32'h0, 32'hDEADBEEF};
    tick();
    WriteEnable = 2'b00; ReadEnable = 2'b11; ReadAddr = {5'd3, 5'd3};
    tick();
    check("t1_rd_p0", 64'(ReadData[31:0]), 64'hDEADBEEF);
    check("t1_rd_p1", 64'(ReadData[63:32]), 64'hDEADBEEF);

    // T2: read-during-write returns old data
    ReadEnable = 2'b00;
    WriteEnable = 2'b01; WriteAddr = {5'd0, 5'd5}; WriteData = {32'h0, 32'h0};
    tick();
    WriteData = {32'h0, 32'h1}; ReadEnable = 2'b01; ReadAddr = {5'd0, 5'd5};
    tick();
    check("t2_old", 64'(ReadData[31:0]), 64'h0);
    WriteEnable = 2'b00;
    tick();
    check("t2_new", 64'(ReadData[31:0]), 64'h1);
    ReadEnable = 2'b00; ReadAddr = {5'd0, 5'd3};
    tick();
    check("t2_hold", 64'(ReadData[31:0]), 64'h1);

    // T3: two ports write same address, higher index wins
    WriteEnable = 2'b11; WriteAddr = {5'd7, 5'd7}; WriteData = {32'hB, 32'hA};
    tick();
    WriteEnable = 2'b00; ReadEnable = 2'b10; ReadAddr = {5'd7, 5'd0};
    tick();
    check("t3_prio", 64'(ReadData[63:32]), 64'hB);
    ReadEnable = 2'b00;

    // T4: full self-test, functional access blocked while busy
    bist_start_i = 1'b1;
    tick();
    bist_start_i = 1'b0;
    lat = 1;
    check("t4_busy", 64'(bist_busy_o), 64'h1);
    check("t4_done_lo", 64'(bist_done_o), 64'h0);
    WriteEnable = 2'b01; WriteAddr = {5'd0, 5'd3}; WriteData = {32'h0, 32'h12345678};
    ReadEnable = 2'b10; ReadAddr = {5'd3, 5'd0};
    tick(); lat++;
    tick(); lat++;
    WriteEnable = 2'b00; ReadEnable = 2'b00;
    check("t4_rd_hold", 64'(ReadData[63:32]), 64'hB);
    while (!bist_done_o && lat < 1000) begin
      tick();
      lat++;
    end
    check("t4_done_cyc", 64'(lat), 64'd353);
    check("t4_fail", 64'(bist_fail_o), 64'h0);
    tick();
    check("t4_busy_end", 64'(bist_busy_o), 64'h0);
    check("t4_done_1cyc", 64'(bist_done_o), 64'h0);
    ReadEnable = 2'b01; ReadAddr = {5'd0, 5'd3};
    tick();
    check("t4_wr_lost", 64'(ReadData[31:0]), 64'h0);
    ReadEnable = 2'b00;

    // T5: stuck-at-1 on bit 0 of word 9
    force dut.mem[9][0] = 1'b1;
    run_bist(lat);
    check("t5_done_cyc", 64'(lat), 64'd353);
    check("t5_fail", 64'(bist_fail_o), 64'h1);
    check("t5_faddr", 64'(bist_fail_addr_o), 64'd9);
    tick();
    check("t5_fail_hold", 64'(bist_fail_o), 64'h1);

    // T6: reset inside R1W0_UP (fault still present, so fail is already set)
    bist_start_i = 1'b1;
    tick();
    bist_start_i = 1'b0;
    repeat (99) tick();
    check("t6_pre_fail", 64'(bist_fail_o), 64'h1);
    check("t6_pre_busy", 64'(bist_busy_o), 64'h1);
    rst_n = 1'b0;
    tick();
    check("t6_busy", 64'(bist_busy_o), 64'h0);
    check("t6_fail", 64'(bist_fail_o), 64'h0);
    check("t6_done", 64'(bist_done_o), 64'h0);
    rst_n = 1'b1;
    release dut.mem[9][0];
    run_bist(lat);
    check("t6_rerun_cyc", 64'(lat), 64'd353);
    check("t6_rerun_fail", 64'(bist_fail_o), 64'h0);
    check("t6_rerun_faddr", 64'(bist_fail_addr_o), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
